// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared op encodings, FSM state type and default width for muldiv.
// Revision : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MLA  = 2'b01;
  localparam logic [1:0] OP_UDIV = 2'b10;
  localparam logic [1:0] OP_SDIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module   : muldiv_step
// Purpose  : One combinational radix-2 iteration, shift-add multiply or
//            restoring divide, selected by mode (0 multiply, 1 divide).
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] aux,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] opnd_nxt,
  output logic [WIDTH-1:0] aux_nxt
);

  logic [WIDTH:0] rem_shift;
  logic           fits;

  // Remainder shifted by one with the next dividend bit; the extra top bit
  // keeps the compare exact when the divisor has its MSB set.
  assign rem_shift = {acc, aux[WIDTH-1]};
  assign fits      = (rem_shift >= {1'b0, opnd});

  always_comb begin
    acc_nxt  = acc;
    opnd_nxt = opnd;
    aux_nxt  = aux;
    if (mode) begin
      if (fits) begin
        acc_nxt = rem_shift[WIDTH-1:0] - opnd;
        aux_nxt = {aux[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_shift[WIDTH-1:0];
        aux_nxt = {aux[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (aux[0]) begin
        acc_nxt = acc + opnd;
      end
      opnd_nxt = opnd << 1;
      aux_nxt  = aux >> 1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Multi-cycle MUL/MLA/UDIV/SDIV sequencer that stalls the core
//            while iterating and pulses done for one cycle with the result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] src_c,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] aux;
  logic             is_div;
  logic             neg;

  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] opnd_step;
  logic [WIDTH-1:0] aux_step;

  logic             accept;
  logic             zero_div;
  logic             last_iter;
  logic             is_sdiv;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] final_val;

  assign accept    = (state == ST_IDLE) && start && !flush;
  assign zero_div  = op[1] && (src_b == '0);
  assign last_iter = (count == CNT_W'(WIDTH - 1));
  assign is_sdiv   = (op == OP_SDIV);

  // Signed divide runs on magnitudes; the sign is restored on completion.
  assign abs_a = (is_sdiv && src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b = (is_sdiv && src_b[WIDTH-1]) ? -src_b : src_b;

  assign final_val = is_div ? (neg ? -aux_step : aux_step) : acc_step;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode     (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .aux      (aux),
    .acc_nxt  (acc_step),
    .opnd_nxt (opnd_step),
    .aux_nxt  (aux_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = zero_div ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (last_iter) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stall is combinational so the core freezes in the request cycle itself.
  always_comb begin
    stall = ((state == ST_IDLE) && start && !flush) || (state == ST_RUN);
    busy  = (state == ST_RUN);
    done  = (state == ST_DONE) && !flush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      aux      <= '0;
      is_div   <= 1'b0;
      neg      <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            count  <= '0;
            is_div <= op[1];
            if (op[1]) begin
              acc  <= '0;
              opnd <= abs_b;
              aux  <= abs_a;
              neg  <= is_sdiv && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
              if (zero_div) begin
                result   <= '0;
                div_zero <= 1'b1;
              end
            end else begin
              acc  <= (op == OP_MLA) ? src_c : '0;
              opnd <= src_a;
              aux  <= src_b;
              neg  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (!flush) begin
            acc   <= acc_step;
            opnd  <= opnd_step;
            aux   <= aux_step;
            count <= count + CNT_W'(1);
            if (last_iter) begin
              result   <= final_val;
              div_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Directed self-checking bench for muldiv_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] src_c;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_zero;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  muldiv_seq #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .src_c    (src_c),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Issues one request, then watches (at negedges) until done or a cycle budget.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, output int dcyc, output int gdone,
                        output logic [31:0] res, output logic dz,
                        output int stall_n, output int last_stall, output int busy_n);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b; src_c = c;
    @(negedge clk);
    stall_n = stall ? 1 : 0;
    last_stall = stall ? 0 : -1;
    busy_n = busy ? 1 : 0;
    dcyc = -1; gdone = -1; res = '0; dz = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 80 && dcyc < 0; k++) begin
      @(negedge clk);
      if (stall) begin stall_n++; last_stall = k; end
      if (busy) busy_n++;
      if (done) begin dcyc = k; gdone = cyc; res = result; dz = div_zero; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 2'b00; flush = 1'b0;
    src_a = '0; src_b = '0; src_c = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({stall, busy, done, div_zero} !== 4'b0000 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: stall/busy/done/dz=%b result=%h, required 0000 / 00000000",
               {stall, busy, done, div_zero}, result);
    end
    reset = 1'b1;
  endtask

  task automatic test_mul();
    int d, g, sn, ls, bn; logic [31:0] r; logic z;
    run_op(OP_MUL, 32'd7, 32'd6, 32'd0, d, g, r, z, sn, ls, bn);
    n_cmp++;
    if (d !== 33) begin n_fail++; $display("FAIL mul_latency: done cycle %0d, required 33", d); end
    n_cmp++;
    if (r !== 32'd42) begin n_fail++; $display("FAIL mul_result: got %h, required %h", r, 32'd42); end
    n_cmp++;
    if (z !== 1'b0) begin n_fail++; $display("FAIL mul_divzero: got %b, required 0", z); end
    n_cmp++;
    if (sn !== 33 || ls !== 32) begin
      n_fail++; $display("FAIL mul_stall: %0d cycles last %0d, required 33 last 32", sn, ls);
    end
    n_cmp++;
    if (bn !== 32) begin n_fail++; $display("FAIL mul_busy: %0d cycles, required 32", bn); end
  endtask

  task automatic test_mla();
    int d, g, sn, ls, bn; logic [31:0] r; logic z;
    run_op(OP_MLA, 32'hFFFF_FFFF, 32'd2, 32'd5, d, g, r, z, sn, ls, bn);
    n_cmp++;
    if (r !== 32'h0000_0003 || d !== 33) begin
      n_fail++; $display("FAIL mla_wrap: got %h at cycle %0d, required 00000003 at 33", r, d);
    end
  endtask

  task automatic test_div();
    int d, g, sn, ls, bn; logic [31:0] r; logic z;
    run_op(OP_SDIV, 32'hFFFF_FF9C, 32'd7, 32'd0, d, g, r, z, sn, ls, bn);
    n_cmp++;
    if (r !== 32'hFFFF_FFF2 || z !== 1'b0) begin
      n_fail++; $display("FAIL sdiv_neg: got %h dz %b, required fffffff2 dz 0", r, z);
    end
    run_op(OP_UDIV, 32'd100, 32'd7, 32'd0, d, g, r, z, sn, ls, bn);
    n_cmp++;
    if (r !== 32'd14 || d !== 33) begin
      n_fail++; $display("FAIL udiv: got %h at cycle %0d, required 0000000e at 33", r, d);
    end
    run_op(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, d, g, r, z, sn, ls, bn);
    n_cmp++;
    if (r !== 32'h8000_0000 || z !== 1'b0) begin
      n_fail++; $display("FAIL sdiv_intmin: got %h dz %b, required 80000000 dz 0", r, z);
    end
    run_op(OP_UDIV, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0, d, g, r, z, sn, ls, bn);
    n_cmp++;
    if (r !== 32'd1) begin n_fail++; $display("FAIL udiv_bigdiv: got %h, required 00000001", r); end
  endtask

  task automatic test_div_zero();
    int d, g, sn, ls, bn; logic [31:0] r; logic z;
    run_op(OP_UDIV, 32'd123, 32'd0, 32'd0, d, g, r, z, sn, ls, bn);
    n_cmp++;
    if (d !== 1) begin n_fail++; $display("FAIL dz_latency: done cycle %0d, required 1", d); end
    n_cmp++;
    if (r !== 32'h0 || z !== 1'b1) begin
      n_fail++; $display("FAIL dz_result: got %h dz %b, required 00000000 dz 1", r, z);
    end
    n_cmp++;
    if (sn !== 1 || ls !== 0 || bn !== 0) begin
      n_fail++; $display("FAIL dz_stall: stall %0d last %0d busy %0d, required 1 0 0", sn, ls, bn);
    end
  endtask

  task automatic test_flush();
    int d, g, sn, ls, bn; logic [31:0] r; logic z; logic seen;
    @(posedge clk); #1;
    start = 1'b1; op = OP_MUL; src_a = 32'h1234_5678; src_b = 32'd9; src_c = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL flush_run: busy %b done %b, required 1 0", busy, done);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: busy %b stall %b, required 0 0", busy, stall);
    end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
    n_cmp++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_nodone: done seen %b, required 0", seen); end
    run_op(OP_MUL, 32'd3, 32'd3, 32'd0, d, g, r, z, sn, ls, bn);
    n_cmp++;
    if (r !== 32'd9 || d !== 33) begin
      n_fail++; $display("FAIL flush_after: got %h at cycle %0d, required 00000009 at 33", r, d);
    end
  endtask

  task automatic test_back_to_back();
    int d1, g1, d2, g2, sn, ls, bn; logic [31:0] r1, r2; logic z; logic seen;
    @(posedge clk); #1;
    start = 1'b1; op = OP_UDIV; src_a = 32'd100; src_b = 32'd7; src_c = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({stall, busy, done, div_zero} !== 4'b0000 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_midrun: stall/busy/done/dz=%b result=%h, required 0000 / 00000000",
               {stall, busy, done, div_zero}, result);
    end
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (done || busy) seen = 1'b1; end
    reset = 1'b1;
    repeat (3) begin @(negedge clk); if (done || busy) seen = 1'b1; end
    n_cmp++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_quiet: activity %b, required 0", seen); end
    run_op(OP_MUL, 32'd2, 32'd3, 32'd0, d1, g1, r1, z, sn, ls, bn);
    run_op(OP_MUL, 32'd4, 32'd5, 32'd0, d2, g2, r2, z, sn, ls, bn);
    n_cmp++;
    if (r1 !== 32'd6 || r2 !== 32'd20) begin
      n_fail++; $display("FAIL b2b_results: got %h %h, required 00000006 00000014", r1, r2);
    end
    n_cmp++;
    if (d1 < 0 || d2 < 0 || (g2 - g1) !== 34) begin
      n_fail++; $display("FAIL b2b_spacing: done pulses %0d apart, required 34", g2 - g1);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mla();
    test_div();
    test_div_zero();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the MUL, MLA, UDIV and SDIV operations of the single-cycle ARM core.
- Accepts one request from the decode/datapath when the op decode fires.
- Asserts stall so the PC and register file hold, iterates a radix-2 shift-add multiplier or restoring divider, then releases the stall for exactly one cycle with the result valid so the core writes back.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 forces all state to reset values.
- start  in  1  request; high while the current instruction is a mul/div op and its condition passes.
- op  in  2  00 MUL, 01 MLA, 10 UDIV, 11 SDIV.
- src_a  in  WIDTH  multiplicand or dividend (Rn).
- src_b  in  WIDTH  multiplier or divisor (Rm).
- src_c  in  WIDTH  MLA addend (Ra); ignored otherwise.
- flush  in  1  synchronous abort; discards the operation in flight.
- stall  out  1  hold PC/IF/register write.
- busy  out  1  state RUN.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  low WIDTH bits of the product/sum, or the quotient.
- div_zero  out  1  valid with done; divisor was 0.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, count 0, all datapath registers 0, stall 0, busy 0, done 0, result 0, div_zero 0.
- IDLE:
  - start=1 latches op and operands at the clock edge.
  - UDIV/SDIV with src_b==0 goes to DONE directly: result 0, div_zero 1.
  - All other requests go to RUN with count=0.
- RUN, multiply: each cycle, if multiplier bit0 then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1.
- RUN, divide: each cycle, shift {rem,quo} left 1 bit. If rem >= divisor then rem -= divisor and quo bit0 = 1.
- RUN: count increments every cycle; after WIDTH cycles (count==WIDTH-1) go to DONE.
- DONE: done=1 for one cycle, then IDLE unconditionally. start is ignored in DONE because it is the same instruction completing.
- Latency: start sampled at edge E0. Normal ops complete at edge E(WIDTH+1), i.e. done=1 during cycle WIDTH+1 (33 for WIDTH=32). Divide-by-zero asserts done in cycle 1.
- stall = (IDLE & start & ~flush) | RUN. It is combinational so the core freezes in the request cycle itself. stall=0 in DONE.
- MLA: acc is initialised to src_c, so result = (src_a*src_b + src_c) mod 2^WIDTH.
- MUL: result = (src_a*src_b) mod 2^WIDTH. Signedness is irrelevant for the low half.
- SDIV:
  - Latch abs(src_a), abs(src_b) and neg = sign_a ^ sign_b.
  - In DONE, result = neg ? -quo : quo, truncated toward zero.
  - INT_MIN / -1 yields INT_MIN with no flag; this falls out of wrap-around negation.
- UDIV: plain unsigned quotient. The remainder is not exported.
- result and div_zero hold their values after DONE until the next DONE; they only matter when done=1.
- flush in RUN or DONE: next state IDLE, no done pulse, stall drops in the following cycle. flush together with start in IDLE: the request is not accepted.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs at reset values; no done.
- Back-to-back requests: a new start is accepted in the IDLE cycle that follows DONE. The minimum spacing between two done pulses is WIDTH+2 cycles.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MUL, OP_MLA, OP_UDIV, OP_SDIV;
  - the state enum {IDLE, RUN, DONE};
  - default WIDTH.
- One sub-module: muldiv_step, a combinational single iteration. Inputs: mode, acc/rem, multiplicand/divisor, multiplier/quo. Outputs: the next-state values. It is reused for both multiply and divide.

Test Plan:
- MUL 7 x 6, start one cycle -> stall high in cycles 0..32; done in cycle 33 with result 42; div_zero 0.
- MLA 0xFFFF_FFFF x 2 + 5 -> result 0x0000_0003 (wrap).
- SDIV -100 / 7 -> result -14 (0xFFFF_FFF2). UDIV 100 / 7 -> 14. SDIV 0x8000_0000 / -1 -> 0x8000_0000.
- UDIV 123 / 0 -> done in cycle 1; result 0; div_zero 1; stall high only in cycle 0.
- flush asserted in RUN cycle 10 -> IDLE next cycle; no done pulse. A later MUL 3 x 3 then returns 9.
- reset driven low at RUN cycle 5, mid-divide -> outputs reset immediately. After release, the back-to-back pair MUL 2 x 3, MUL 4 x 5 gives done pulses 34 cycles apart with results 6 and 20.
